// File: rtl/seq_arb_pkg.sv
// Shared types for the clocked-to-self-timed stage arbiter.
// Holds the FSM state enum and synchronizer depth.
package seq_arb_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT_ACK_HI,
    WAIT_ACK_LO,
    RELEASE
  } state_e;

endpackage

// File: rtl/sync2_m.sv
// Two-flop synchronizer for a 1-bit asynchronous level.
// Ports: clk_i, rst_i (async high), d_i (async in), q_o (synced out).
module sync2_m
  import seq_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/seq_stage_arbiter.sv
// Round-robin arbiter driving one bundled-data 4-phase stage input.
// Ports: aclk, reset; req_in/ack_out/data_in per requester;
// stage_req_out/stage_ack_in/stage_data_out to the stage;
// grant_id, busy, timeout_err status.
module seq_stage_arbiter
  import seq_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int WIDTH        = 1,
  parameter int SETUP_CYCLES = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                     aclk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_in,
  output logic [NREQ-1:0]          ack_out,
  input  logic [NREQ*WIDTH-1:0]    data_in,
  output logic                     stage_req_out,
  input  logic                     stage_ack_in,
  output logic [WIDTH-1:0]         stage_data_out,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int IDW = $clog2(NREQ);

  // MSB flags a hit; low bits are the winner. Scanning
  // downward lets the nearest requester after ptr win.
  function automatic logic [IDW:0] rr_pick(
    input logic [NREQ-1:0] req,
    input logic [IDW-1:0]  ptr
  );
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        res = {1'b1, IDW'(idx)};
      end
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sreq_q, sreq_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             err_q, err_d;
  logic [3:0]       scnt_q, scnt_d;
  logic [15:0]      tcnt_q, tcnt_d;
  logic             ack_s;
  logic [IDW:0]     pick;
  logic [IDW-1:0]   pick_id;

  sync2_m u_sync (
    .clk_i (aclk),
    .rst_i (reset),
    .d_i   (stage_ack_in),
    .q_o   (ack_s)
  );

  assign pick    = rr_pick(req_in, ptr_q);
  assign pick_id = pick[IDW-1:0];

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      ptr_q   <= IDW'(NREQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      sreq_q  <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      scnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      sreq_q  <= sreq_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      scnt_q  <= scnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    sreq_d  = sreq_q;
    ack_d   = ack_q;
    err_d   = err_q;
    scnt_d  = scnt_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      IDLE: begin
        // A stale high ack means the stage has not
        // returned to zero; starting now would skip it.
        if (pick[IDW] && !ack_s) begin
          grant_d = pick_id;
          data_d  = data_in[int'(pick_id)*WIDTH +: WIDTH];
          scnt_d  = 4'(SETUP_CYCLES);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (scnt_q == 4'd1) begin
          sreq_d  = 1'b1;
          tcnt_d  = 16'(TIMEOUT);
          state_d = WAIT_ACK_HI;
        end else begin
          scnt_d = scnt_q - 4'd1;
        end
      end
      WAIT_ACK_HI: begin
        if (ack_s) begin
          sreq_d  = 1'b0;
          tcnt_d  = 16'(TIMEOUT);
          state_d = WAIT_ACK_LO;
        end else if (tcnt_q == 16'd1) begin
          err_d   = 1'b1;
          sreq_d  = 1'b0;
          state_d = WAIT_ACK_LO;
        end else begin
          tcnt_d = tcnt_q - 16'd1;
        end
      end
      WAIT_ACK_LO: begin
        // Once an error is flagged the transfer is lost
        // and the arbiter parks here until reset.
        if (!err_q) begin
          if (!ack_s) begin
            ack_d          = '0;
            ack_d[grant_q] = 1'b1;
            ptr_d          = grant_q;
            state_d        = RELEASE;
          end else if (tcnt_q == 16'd1) begin
            err_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q - 16'd1;
          end
        end
      end
      RELEASE: begin
        if (!req_in[grant_q]) begin
          ack_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ack_out        = ack_q;
    stage_req_out  = sreq_q;
    stage_data_out = data_q;
    grant_id       = grant_q;
    busy           = (state_q != IDLE);
    timeout_err    = err_q;
  end

endmodule

// File: tb/tb_seq_stage_arbiter.sv
// Bench for seq_stage_arbiter with a behavioural 4-phase stage.
// Checks latency, round-robin order, setup, timeout and reset.
module tb_seq_stage_arbiter;

  localparam int NREQ  = 4;
  localparam int W     = 8;
  localparam int SETUP = 4;
  localparam int TMO   = 10;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req_in;
  logic [NREQ-1:0] ack_out;
  logic [NREQ*W-1:0] data_in;
  logic            stage_req_out;
  logic            stage_ack_in;
  logic [W-1:0]    stage_data_out;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic model_ack;
  logic manual_ack;
  bit   stage_en;
  int   dly;
  int   mcnt;
  int   ack_fall_cyc;

  seq_stage_arbiter #(
    .NREQ         (NREQ),
    .WIDTH        (W),
    .SETUP_CYCLES (SETUP),
    .TIMEOUT      (TMO)
  ) dut (
    .aclk           (clk),
    .reset          (rst),
    .req_in         (req_in),
    .ack_out        (ack_out),
    .data_in        (data_in),
    .stage_req_out  (stage_req_out),
    .stage_ack_in   (stage_ack_in),
    .stage_data_out (stage_data_out),
    .grant_id       (grant_id),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign stage_ack_in = stage_en ? model_ack : manual_ack;

  // Stage model: ack follows req after dly cycles.
  initial begin
    model_ack    = 1'b0;
    mcnt         = 0;
    ack_fall_cyc = 0;
    forever begin
      @(negedge clk);
      if (!stage_en) begin
        model_ack = 1'b0;
        mcnt      = 0;
      end else if (stage_req_out != model_ack) begin
        mcnt++;
        if (mcnt >= dly) begin
          model_ack = stage_req_out;
          mcnt      = 0;
          if (!stage_req_out) ack_fall_cyc = cyc;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  function automatic int rr(int last, logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    vectors++;
    if (ack_out !== '0 || stage_req_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_acks: ack=%b req=%b want 0",
               ack_out, stage_req_out);
    end
    vectors++;
    if (stage_data_out !== '0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_data: data=%h gid=%0d want 0",
               stage_data_out, grant_id);
    end
    vectors++;
    if (busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b err=%b want 0",
               busy, timeout_err);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    int c0;
    int t;
    logic [W-1:0] d;
    stage_en = 1'b1;
    dly      = 5;
    d        = W'($urandom_range(1, 255));
    data_in  = '0;
    data_in[2*W +: W] = d;
    req_in   = 4'b0100;
    c0       = cyc;
    t        = 0;
    do begin
      tick(1);
      t++;
    end while (!stage_req_out && t < 50);
    vectors++;
    if (cyc - c0 != 1 + SETUP) begin
      errors++;
      $display("FAIL single_latency: got %0d want %0d",
               cyc - c0, 1 + SETUP);
    end
    vectors++;
    if (grant_id !== 2'd2 || stage_data_out !== d) begin
      errors++;
      $display("FAIL single_grant: gid=%0d data=%h want 2 %h",
               grant_id, stage_data_out, d);
    end
    t = 0;
    while (ack_out == '0 && t < 60) begin
      tick(1);
      t++;
    end
    vectors++;
    if (ack_out !== 4'b0100) begin
      errors++;
      $display("FAIL single_ack: got %b want 0100", ack_out);
    end
    vectors++;
    if (cyc - ack_fall_cyc != 3) begin
      errors++;
      $display("FAIL single_ack_sync: got %0d want 3",
               cyc - ack_fall_cyc);
    end
    req_in = '0;
    tick(1);
    vectors++;
    if (busy !== 1'b0 || ack_out !== '0) begin
      errors++;
      $display("FAIL single_release: busy=%b ack=%b want 0 0",
               busy, ack_out);
    end
  endtask

  task automatic test_round_robin();
    int last;
    int exp;
    int t;
    do_reset();
    stage_en = 1'b1;
    dly      = 2;
    last     = NREQ - 1;
    for (int i = 0; i < NREQ; i++) data_in[i*W +: W] = W'($urandom);
    req_in = '1;
    for (int n = 0; n < NREQ + 1; n++) begin
      exp = rr(last, req_in);
      t   = 0;
      while (ack_out == '0 && t < 60) begin
        tick(1);
        t++;
      end
      vectors++;
      if (ack_out !== 4'(1 << exp) || grant_id !== 2'(exp)) begin
        errors++;
        $display("FAIL rr_order[%0d]: ack=%b gid=%0d want gid %0d",
                 n, ack_out, grant_id, exp);
      end
      vectors++;
      if (stage_data_out !== data_in[exp*W +: W]) begin
        errors++;
        $display("FAIL rr_data[%0d]: got %h want %h",
                 n, stage_data_out, data_in[exp*W +: W]);
      end
      last        = exp;
      req_in[exp] = 1'b0;
      tick(1);
      vectors++;
      if (ack_out !== '0) begin
        errors++;
        $display("FAIL rr_double[%0d]: ack=%b want 0", n, ack_out);
      end
      data_in[exp*W +: W] = W'($urandom);
      req_in[exp]         = 1'b1;
    end
    req_in = '0;
    tick(3);
  endtask

  task automatic test_setup_timing();
    int r;
    int t;
    int lc;
    bit stable;
    logic [W-1:0] d;
    do_reset();
    stage_en = 1'b1;
    dly      = 3;
    r        = $urandom_range(0, NREQ - 1);
    d        = W'($urandom);
    data_in[r*W +: W] = d;
    req_in   = 4'(1 << r);
    t        = 0;
    while (!busy && t < 20) begin
      tick(1);
      t++;
    end
    lc     = cyc;
    stable = (stage_data_out === d);
    t      = 0;
    while (!stage_req_out && t < 40) begin
      tick(1);
      t++;
      if (stage_data_out !== d) stable = 1'b0;
    end
    vectors++;
    if (cyc - lc != SETUP) begin
      errors++;
      $display("FAIL setup_cycles: got %0d want %0d",
               cyc - lc, SETUP);
    end
    t = 0;
    while (ack_out == '0 && t < 60) begin
      tick(1);
      t++;
      if (stage_data_out !== d) stable = 1'b0;
    end
    vectors++;
    if (!stable || ack_out !== 4'(1 << r)) begin
      errors++;
      $display("FAIL setup_stable: data=%h ack=%b want %h %b",
               stage_data_out, ack_out, d, 4'(1 << r));
    end
    req_in = '0;
    tick(2);
  endtask

  task automatic test_random();
    int last;
    int exp_g;
    int nx;
    int t;
    bit ack_seen;
    bit busy_prev;
    logic [NREQ-1:0]   prev_req;
    logic [NREQ*W-1:0] prev_data;
    do_reset();
    stage_en  = 1'b1;
    last      = NREQ - 1;
    exp_g     = -1;
    nx        = 0;
    ack_seen  = 1'b0;
    busy_prev = 1'b0;
    req_in    = '0;
    for (int s = 0; s < 700; s++) begin
      prev_req  = req_in;
      prev_data = data_in;
      tick(1);
      if (busy && !busy_prev) begin
        exp_g = rr(last, prev_req);
        vectors++;
        if (exp_g < 0 || grant_id !== 2'(exp_g) ||
            stage_data_out !== prev_data[exp_g*W +: W]) begin
          errors++;
          $display("FAIL rand_grant: gid=%0d data=%h want %0d",
                   grant_id, stage_data_out, exp_g);
        end
      end
      if (ack_out != '0 && !ack_seen) begin
        ack_seen = 1'b1;
        nx++;
        vectors++;
        if (exp_g < 0 || ack_out !== 4'(1 << exp_g)) begin
          errors++;
          $display("FAIL rand_ack: got %b want id %0d",
                   ack_out, exp_g);
        end
        last = exp_g;
      end
      if (ack_out == '0) ack_seen = 1'b0;
      busy_prev = busy;
      for (int i = 0; i < NREQ; i++) begin
        if (req_in[i] && ack_out[i]) begin
          if ($urandom_range(0, 2) == 0) req_in[i] = 1'b0;
        end else if (!req_in[i] && !ack_out[i] && s < 640) begin
          if ($urandom_range(0, 7) == 0) begin
            data_in[i*W +: W] = W'($urandom);
            req_in[i]         = 1'b1;
          end
        end
      end
      dly = $urandom_range(1, 5);
    end
    vectors++;
    if (nx < 10 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rand_progress: xfers=%0d err=%b want >=10 0",
               nx, timeout_err);
    end
    req_in = '0;
    t      = 0;
    while (busy && t < 100) begin
      tick(1);
      t++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: busy=%b want 0", busy);
    end
  endtask

  task automatic test_timeout();
    int t;
    int rc;
    bit quiet;
    do_reset();
    stage_en   = 1'b0;
    manual_ack = 1'b0;
    data_in[0 +: W] = W'($urandom);
    req_in     = 4'b0001;
    t          = 0;
    while (!stage_req_out && t < 30) begin
      tick(1);
      t++;
    end
    rc = cyc;
    t  = 0;
    while (!timeout_err && t < 40) begin
      tick(1);
      t++;
    end
    vectors++;
    if (cyc - rc != TMO) begin
      errors++;
      $display("FAIL timeout_delay: got %0d want %0d",
               cyc - rc, TMO);
    end
    vectors++;
    if (stage_req_out !== 1'b0 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_req: req=%b err=%b want 0 1",
               stage_req_out, timeout_err);
    end
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ack_out !== '0 || busy !== 1'b1 ||
          stage_req_out !== 1'b0) quiet = 1'b0;
    end
    vectors++;
    if (!quiet) begin
      errors++;
      $display("FAIL timeout_blocked: ack=%b busy=%b want 0 1",
               ack_out, busy);
    end
    rst = 1'b1;
    tick(1);
    vectors++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: err=%b busy=%b want 0 0",
               timeout_err, busy);
    end
    req_in = '0;
    rst    = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_mid();
    int t;
    do_reset();
    stage_en = 1'b0;
    data_in[2*W +: W] = W'($urandom);
    req_in   = 4'b0100;
    t        = 0;
    while (!stage_req_out && t < 30) begin
      tick(1);
      t++;
    end
    tick(2);
    vectors++;
    if (stage_req_out !== 1'b1 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL mid_pre: req=%b gid=%0d want 1 2",
               stage_req_out, grant_id);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (stage_req_out !== 1'b0 || ack_out !== '0 ||
        busy !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: req=%b ack=%b busy=%b gid=%0d",
               stage_req_out, ack_out, busy, grant_id);
    end
    req_in = '0;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_stale_ack();
    int t;
    int c0;
    logic [W-1:0] d;
    do_reset();
    stage_en   = 1'b0;
    manual_ack = 1'b1;
    tick(4);
    d          = W'($urandom);
    data_in[0 +: W] = d;
    req_in     = 4'b0001;
    tick(8);
    vectors++;
    if (busy !== 1'b0 || stage_req_out !== 1'b0) begin
      errors++;
      $display("FAIL stale_hold: busy=%b req=%b want 0 0",
               busy, stage_req_out);
    end
    manual_ack = 1'b0;
    c0         = cyc;
    t          = 0;
    while (!busy && t < 20) begin
      tick(1);
      t++;
    end
    vectors++;
    if (cyc - c0 != 3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stale_start: got %0d want 3", cyc - c0);
    end
    stage_en = 1'b1;
    dly      = 2;
    t        = 0;
    while (ack_out == '0 && t < 60) begin
      tick(1);
      t++;
    end
    vectors++;
    if (ack_out !== 4'b0001 || stage_data_out !== d) begin
      errors++;
      $display("FAIL stale_xfer: ack=%b data=%h want 0001 %h",
               ack_out, stage_data_out, d);
    end
    req_in = '0;
    tick(1);
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stale_idle: busy=%b want 0", busy);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_in     = '0;
    data_in    = '0;
    stage_en   = 1'b0;
    manual_ack = 1'b0;
    dly        = 3;
    test_reset();
    test_single();
    test_round_robin();
    test_setup_timing();
    test_random();
    test_timeout();
    test_reset_mid();
    test_stale_ack();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/seq_stage_arbiter.md
Name: seq_stage_arbiter

Overview:
- Clocked round-robin arbiter that shares one bundled-data 4-phase pipeline stage input (left_req_in/left_ack_out/data_in of a seq_ctrl_m stage) among NREQ synchronous requesters.
- Sequences the full handshake toward the stage: mux data, wait setup, raise req, wait ack, drop req, wait ack low.
- Reports the granted requester.
- Sits at the boundary between clocked control logic and the self-timed datapath.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 1, data width; matches the stage WIDTH.
- SETUP_CYCLES, 2, aclk cycles that stage_data_out is held stable before stage_req_out rises (1..15).
- TIMEOUT, 255, aclk cycles to wait for any stage_ack_in edge before flagging an error (1..65535).

Ports:
- aclk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_in  in  NREQ  per-requester request; held high until matching ack_out.
- ack_out  out  NREQ  per-requester completion; one-hot or zero.
- data_in  in  NREQ*WIDTH  requester i owns bits [i*WIDTH +: WIDTH]; stable while req_in[i] is high.
- stage_req_out  out  1  to the stage left_req_in.
- stage_ack_in  in  1  from the stage left_ack_out; asynchronous, synchronized internally.
- stage_data_out  out  WIDTH  to the stage data_in.
- grant_id  out  $clog2(NREQ)  index of the current or last grant.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; cleared only by reset.

Behaviour:
- Reset: asynchronous and active-high. Clears all of the following:
  - state=IDLE; ack_out=0; stage_req_out=0; stage_data_out=0; grant_id=0; busy=0; timeout_err=0.
  - Round-robin pointer=NREQ-1, so requester 0 has first priority.
  - Both synchronizer flops =0.
- Synchronizer: stage_ack_in passes through 2 flops to give ack_s. All decisions use ack_s.
- FSM states:
  - IDLE: if any req_in is high and ack_s==0, pick the first requester searching upward from pointer+1 (wrapping). Latch its index into grant_id, latch its data into stage_data_out, load the setup counter, go to SETUP. If ack_s==1 (stage not yet returned to zero), stay in IDLE.
  - SETUP: decrement the counter. When it reaches 0, set stage_req_out=1 and go to WAIT_ACK_HI. Minimum SETUP_CYCLES cycles from latch to req rising.
  - WAIT_ACK_HI: when ack_s==1, set stage_req_out=0 and go to WAIT_ACK_LO.
  - WAIT_ACK_LO: when ack_s==0, set ack_out[grant_id]=1, set pointer=grant_id, go to RELEASE.
  - RELEASE: hold ack_out until req_in[grant_id]==0, then clear ack_out and go to IDLE. The next arbitration is possible the cycle after IDLE is entered.
- Timeout:
  - A counter is loaded on entry to WAIT_ACK_HI and WAIT_ACK_LO.
  - If it expires before the awaited ack_s level: set timeout_err=1 and force stage_req_out=0.
  - From WAIT_ACK_HI the FSM goes to WAIT_ACK_LO (no requester ack, the transfer is lost).
  - From WAIT_ACK_LO the FSM continues waiting for ack_s==0. The counter is not reloaded and the error stays sticky.
  - The transfer that caused the timeout is never acknowledged to its requester. The FSM stays blocked until reset.
- Boundaries:
  - stage_data_out changes only on the IDLE→SETUP latch. It is stable from the latch through WAIT_ACK_LO.
  - A requester dropping req_in before ack_out is a protocol violation. The FSM ignores it and completes the transfer.
  - Requests arriving mid-transfer are queued implicitly: req_in stays high.
  - The granted requester re-requesting after RELEASE gets the lowest priority.
  - With all requesters active, the grant order is 0,1,..,NREQ-1,0.
  - Reset mid-handshake drops stage_req_out at once. The stage is responsible for its own recovery.
- Latency: request-to-stage_req_out = 1 (arbitration) + SETUP_CYCLES cycles. Requester-visible latency adds stage delay + 2×2 synchronizer cycles.

Decomposition:
- Package seq_arb_pkg: state enum (IDLE, SETUP, WAIT_ACK_HI, WAIT_ACK_LO, RELEASE) and the SYNC_STAGES=2 constant.
- Sub-module sync2_m: 1-bit two-flop synchronizer with async active-high reset. It is reused elsewhere for other stage acks.
- The round-robin pick is a function inside the arbiter.

Test Plan:
1. Single request: NREQ=4, SETUP_CYCLES=2, req_in=0100, data_in[2]=1. Expect:
   - grant_id=2; stage_data_out=1.
   - stage_req_out rises 3 cycles after req.
   - Model ack responds after 5 cycles; ack_out=0100 after ack low is synchronized.
   - busy drops the cycle after req_in[2] falls.
2. Round robin: req_in=1111 held, each requester re-raising after its ack. Expect grant_id sequence 0,1,2,3,0 and no double grant.
3. Setup timing: SETUP_CYCLES=4. Check stage_data_out is stable ≥4 cycles before stage_req_out rises and unchanged until ack_s falls.
4. Timeout: TIMEOUT=10, stage never acks. Expect:
   - timeout_err=1 10 cycles after stage_req_out rises.
   - stage_req_out=0 and ack_out stays 0.
   - After reset: timeout_err=0, state IDLE.
5. Reset mid-transfer: assert reset in WAIT_ACK_HI. Expect stage_req_out=0, ack_out=0, busy=0 immediately without waiting for a clock edge, and grant_id=0.
6. Stale ack: stage_ack_in still high at IDLE with req_in=0001. Expect no grant until ack_s==0, then normal transfer.
